load_store_unit: RTL

Multi-cycle load/store unit sitting directly downstream of the single-cycle RV32I datapath's ALU. It takes the ALU address and the rs2 value and drives a request/acknowledge data-memory port. It generates byte enables and lane-shifted write data for SB/SH/SW, and sign- or zero-extends LB/LH/LBU/LHU/LW results. While an access is outstanding it asserts `stall_o` so the core holds PC and register write-back.

---
 rtl/load_store_unit_if.sv | 23 ++
 rtl/load_store_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit.
// master: the LSU drives request, write-enable, word address, byte enables
//         and write data; it receives ack and the read word.
// slave : the memory side.
interface load_store_unit_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit with a req/ack data-memory port.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   load_i, store_i    access request from the core (store wins if both set)
//   fun3_i             instr[14:12]: width and sign of the access
//   addr_i, wdata_i    byte address (ALU result) and store data (rs2)
//   stall_o            hold PC / suppress write-back while the access runs
//   done_o             one-cycle completion pulse, rdata_o valid
//   rdata_o            extended load result
//   misalign_o         with done_o: misaligned address or bad fun3
//   fault_o            with done_o: memory did not ack within TIMEOUT cycles
//   mem                data-memory port (master side)
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              store_i,
    input  logic [2:0]        fun3_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              misalign_o,
    output logic              fault_o,
    load_store_unit_if.master mem
);

    localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [1:0]    lane_q, lane_d;
    logic [2:0]    fun3_q, fun3_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          mis_q, mis_d;
    logic          flt_q, flt_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          acc, f3_ok, aligned, illegal, timeout_hit;
    logic [3:0]    be_acc;
    logic [31:0]   wdata_acc;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   ld_ext;

    // Accept-time decode of the incoming request.
    always_comb begin
        acc   = load_i | store_i;
        f3_ok = 1'b0;
        if (store_i) begin
            f3_ok = (fun3_i == 3'b000) || (fun3_i == 3'b001) || (fun3_i == 3'b010);
        end else begin
            case (fun3_i)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
                default:                                f3_ok = 1'b0;
            endcase
        end
        case (fun3_i[1:0])
            2'b01:   aligned = ~addr_i[0];
            2'b10:   aligned = (addr_i[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        illegal = ~(f3_ok & aligned);
        case (fun3_i[1:0])
            2'b00: begin
                be_acc    = 4'b0001 << addr_i[1:0];
                wdata_acc = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_acc    = 4'b0011 << addr_i[1:0];
                wdata_acc = {2{wdata_i[15:0]}};
            end
            default: begin
                be_acc    = 4'b1111;
                wdata_acc = wdata_i;
            end
        endcase
    end

    // Load extension from the latched lane and fun3.
    always_comb begin
        case (lane_q)
            2'd0:    byte_v = mem.mem_rdata_i[7:0];
            2'd1:    byte_v = mem.mem_rdata_i[15:8];
            2'd2:    byte_v = mem.mem_rdata_i[23:16];
            default: byte_v = mem.mem_rdata_i[31:24];
        endcase
        half_v = lane_q[1] ? mem.mem_rdata_i[31:16] : mem.mem_rdata_i[15:0];
        case (fun3_q)
            3'b000:  ld_ext = {{24{byte_v[7]}}, byte_v};
            3'b100:  ld_ext = {24'b0, byte_v};
            3'b001:  ld_ext = {{16{half_v[15]}}, half_v};
            3'b101:  ld_ext = {16'b0, half_v};
            default: ld_ext = mem.mem_rdata_i;
        endcase
    end

    // Counter reaches TIMEOUT at this edge if the memory stays silent.
    assign timeout_hit = (cnt_q == CNT_LAST) & ~mem.mem_ack_i;

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (acc) state_d = illegal ? S_DONE : S_REQ;
            S_REQ:   if (mem.mem_ack_i || timeout_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs. mem_req_o comes straight from the state register.
    always_comb begin
        stall_o         = ((state_q == S_IDLE) & acc) | (state_q == S_REQ);
        done_o          = (state_q == S_DONE);
        misalign_o      = done_o & mis_q;
        fault_o         = done_o & flt_q;
        rdata_o         = rdata_q;
        mem.mem_req_o   = (state_q == S_REQ);
        mem.mem_we_o    = we_q;
        mem.mem_addr_o  = addr_q;
        mem.mem_be_o    = be_q;
        mem.mem_wdata_o = wdata_q;
    end

    // Datapath next state.
    always_comb begin
        addr_d  = addr_q;
        lane_d  = lane_q;
        fun3_d  = fun3_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        flt_d   = flt_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    addr_d  = {addr_i[31:2], 2'b00};
                    lane_d  = addr_i[1:0];
                    fun3_d  = fun3_i;
                    we_d    = store_i;
                    be_d    = be_acc;
                    wdata_d = wdata_acc;
                    cnt_d   = '0;
                    mis_d   = illegal;
                    flt_d   = 1'b0;
                    if (illegal) rdata_d = '0;
                end
            end
            S_REQ: begin
                if (mem.mem_ack_i) begin
                    if (!we_q) rdata_d = ld_ext;
                end else begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    if (timeout_hit) begin
                        flt_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            lane_q  <= '0;
            fun3_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            flt_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            fun3_q  <= fun3_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            flt_q   <= flt_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
